// File: rtl/mux8_seq_pkg.sv
// Shared types and constants for the 8:1 mux bit sequencer.
package mux8_seq_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Starting select value for LSB-first and MSB-first serialization.
  localparam logic [SEL_W-1:0] SEL_FIRST_LSB = 3'd0;
  localparam logic [SEL_W-1:0] SEL_FIRST_MSB = 3'd7;

endpackage

// File: rtl/mux8_bit_sequencer_timer.sv
// Hold timer: counts cycles a select value has been held and flags the last one.
module bit_hold_timer #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  // A single-cycle hold still gets a 1-bit counter that simply stays at zero.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;

  assign tick = (hold_cnt == CNT_LAST);

  // Count while enabled, wrap to zero after the last hold cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      hold_cnt <= '0;
    end else if (en) begin
      hold_cnt <= tick ? '0 : hold_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux8_bit_sequencer.sv
// Byte serializer control for an 8:1 bit-select mux: latches a byte on a
// valid/ready handshake, steps the select through all eight positions and
// raises framing flags plus a one-cycle done pulse.
//
// Handshake: a byte transfers on a rising edge where s_valid and s_ready are
// both high; s_ready is high only in IDLE outside reset, and s_data is
// ignored on every other edge.
module mux8_bit_sequencer
  import mux8_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              abort,
  output logic [DATA_W-1:0] mux_in,
  output logic [SEL_W-1:0]  mux_sel,
  output logic              bit_valid,
  output logic              bit_first,
  output logic              bit_last,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_FIRST_MSB : SEL_FIRST_LSB;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0] mux_in_d;
  logic [SEL_W-1:0]  sel_d;
  logic              valid_d, first_d, last_d, done_d;
  logic              tick;

  assign s_ready   = (state_q == IDLE) && rst_n;
  assign busy      = (state_q == SHIFT);
  assign dbg_state = state_q;

  bit_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear((state_q != SHIFT) || abort),
    .en   (state_q == SHIFT),
    .tick (tick)
  );

  // Next state, select stepping and framing flags; abort outranks stepping.
  always_comb begin
    state_d   = state_q;
    mux_in_d  = mux_in;
    sel_d     = mux_sel;
    bit_cnt_d = bit_cnt;
    valid_d   = bit_valid;
    first_d   = bit_first;
    last_d    = bit_last;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid && s_ready) begin
          state_d   = SHIFT;
          mux_in_d  = s_data;
          sel_d     = SEL_START;
          bit_cnt_d = 3'd0;
          valid_d   = 1'b1;
          first_d   = 1'b1;
          last_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (abort || (tick && bit_cnt == 3'd7)) begin
          state_d = IDLE;
          sel_d   = '0;
          valid_d = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
          done_d  = !abort;
        end else if (tick) begin
          bit_cnt_d = bit_cnt + 3'd1;
          sel_d     = MSB_FIRST ? (mux_sel - 3'd1) : (mux_sel + 3'd1);
          first_d   = 1'b0;
          last_d    = (bit_cnt == 3'd6);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mux_in    <= '0;
      mux_sel   <= '0;
      bit_cnt   <= '0;
      bit_valid <= 1'b0;
      bit_first <= 1'b0;
      bit_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mux_in    <= mux_in_d;
      mux_sel   <= sel_d;
      bit_cnt   <= bit_cnt_d;
      bit_valid <= valid_d;
      bit_first <= first_d;
      bit_last  <= last_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_mux8_bit_sequencer.sv
// Bench for mux8_bit_sequencer: two instances (HOLD=1 LSB-first and HOLD=3
// MSB-first) share one stimulus stream; a cycle-level model tracks each byte
// as a position count and is compared every cycle, and directed scenarios
// pin the model with literal expectations.
module tb_mux8_bit_sequencer;
  import mux8_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       abort = 1'b0;

  logic       s_ready_w [2];
  logic [7:0] mux_in_w  [2];
  logic [2:0] sel_w     [2];
  logic       valid_w   [2];
  logic       first_w   [2];
  logic       last_w    [2];
  logic       busy_w    [2];
  logic       done_w    [2];
  state_t     dbg_w     [2];

  int checks = 0;
  int failures = 0;

  // Reference model state per instance.
  int  hold_of [2] = '{1, 3};
  bit  msb_of  [2] = '{1'b0, 1'b1};
  bit  m_busy  [2] = '{1'b0, 1'b0};
  int  m_t     [2] = '{0, 0};
  logic [7:0] m_data [2] = '{8'h00, 8'h00};
  bit  m_done  [2] = '{1'b0, 1'b0};

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  mux8_bit_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w[0]),
    .s_data(s_data), .abort(abort), .mux_in(mux_in_w[0]), .mux_sel(sel_w[0]),
    .bit_valid(valid_w[0]), .bit_first(first_w[0]), .bit_last(last_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .dbg_state(dbg_w[0])
  );

  mux8_bit_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w[1]),
    .s_data(s_data), .abort(abort), .mux_in(mux_in_w[1]), .mux_sel(sel_w[1]),
    .bit_valid(valid_w[1]), .bit_first(first_w[1]), .bit_last(last_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .dbg_state(dbg_w[1])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: advance the model on each edge, then compare every output.
  always @(posedge clk) begin
    logic rn, sv, ab;
    logic [7:0] sd;
    rn = rst_n; sv = s_valid; ab = abort; sd = s_data;
    #1;
    for (int i = 0; i < 2; i++) begin
      int h, b, esel;
      h = hold_of[i];
      if (!rn) begin
        m_busy[i] = 1'b0; m_t[i] = 0; m_data[i] = 8'h00; m_done[i] = 1'b0;
      end else if (m_busy[i]) begin
        m_done[i] = 1'b0;
        if (ab) m_busy[i] = 1'b0;
        else if (m_t[i] == 8 * h - 1) begin
          m_busy[i] = 1'b0; m_done[i] = 1'b1;
        end else m_t[i]++;
      end else begin
        m_done[i] = 1'b0;
        if (sv) begin
          m_busy[i] = 1'b1; m_t[i] = 0; m_data[i] = sd;
        end
      end
      b = m_t[i] / h;
      esel = m_busy[i] ? (msb_of[i] ? 7 - b : b) : 0;
      check($sformatf("u%0d mux_sel", i), int'(sel_w[i]), esel);
      check($sformatf("u%0d mux_in", i), int'(mux_in_w[i]), int'(m_data[i]));
      check($sformatf("u%0d bit_valid", i), int'(valid_w[i]), int'(m_busy[i]));
      check($sformatf("u%0d bit_first", i), int'(first_w[i]), int'(m_busy[i] && b == 0));
      check($sformatf("u%0d bit_last", i), int'(last_w[i]), int'(m_busy[i] && b == 7));
      check($sformatf("u%0d busy", i), int'(busy_w[i]), int'(m_busy[i]));
      check($sformatf("u%0d done", i), int'(done_w[i]), int'(m_done[i]));
      check($sformatf("u%0d s_ready", i), int'(s_ready_w[i]), int'(!m_busy[i] && rst_n));
      check($sformatf("u%0d dbg_state", i), int'(dbg_w[i] == SHIFT), int'(m_busy[i]));
    end
  end

  // Driver: pulse reset and pin the reset values.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst u%0d mux_in", i), int'(mux_in_w[i]), 0);
      check($sformatf("rst u%0d mux_sel", i), int'(sel_w[i]), 0);
      check($sformatf("rst u%0d flags", i),
            int'({valid_w[i], first_w[i], last_w[i], busy_w[i], done_w[i]}), 0);
      check($sformatf("rst u%0d s_ready", i), int'(s_ready_w[i]), 1);
    end
  endtask

  // Driver: present a byte for one cycle (cycle 0 of a scenario).
  task automatic offer(input logic [7:0] d);
    @(negedge clk);
    s_valid = 1'b1; s_data = d;
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;

    // 1: HOLD=1 LSB-first 8'hA5.
    do_reset();
    offer(8'hA5);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        check("t1 sel", int'(sel_w[0]), c - 1);
        check("t1 mux bit", int'(mux_in_w[0][sel_w[0]]), int'(a5[c - 1]));
        check("t1 first", int'(first_w[0]), int'(c == 1));
        check("t1 last", int'(last_w[0]), int'(c == 8));
        check("t1 done low", int'(done_w[0]), 0);
      end else begin
        check("t1 done", int'(done_w[0]), 1);
        check("t1 s_ready", int'(s_ready_w[0]), 1);
        check("t1 valid end", int'(valid_w[0]), 0);
      end
      if (c == 1) s_valid = 1'b0;
    end

    // 2: HOLD=3 MSB-first 8'h3C.
    do_reset();
    offer(8'h3C);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c <= 24) begin
        check("t2 sel", int'(sel_w[1]), 7 - (c - 1) / 3);
        check("t2 s_ready", int'(s_ready_w[1]), 0);
        check("t2 done low", int'(done_w[1]), 0);
      end else begin
        check("t2 done", int'(done_w[1]), 1);
        check("t2 s_ready end", int'(s_ready_w[1]), 1);
      end
      if (c == 1) s_valid = 1'b0;
    end
    check("t2 sel end", int'(sel_w[1]), 0);

    // 3: back-to-back with s_valid held, HOLD=1.
    do_reset();
    offer(8'hFF);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      check("t3 valid", int'(valid_w[0]), int'(c != 9 && c <= 17));
      if (c == 9)  check("t3 done", int'(done_w[0]), 1);
      if (c == 8)  check("t3 byte0", int'(mux_in_w[0]), 8'hFF);
      if (c == 10) check("t3 byte1", int'(mux_in_w[0]), 8'h00);
      if (c == 10) check("t3 first1", int'(first_w[0]), 1);
      if (c == 1)  s_data = 8'h00;
      if (c == 10) s_valid = 1'b0;
    end

    // 4: abort in cycle 4, HOLD=1.
    do_reset();
    offer(8'h96);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 5) begin
        check("t4 valid", int'(valid_w[0]), 0);
        check("t4 sel", int'(sel_w[0]), 0);
        check("t4 busy", int'(busy_w[0]), 0);
        check("t4 s_ready", int'(s_ready_w[0]), 1);
        check("t4 mux_in", int'(mux_in_w[0]), 8'h96);
      end
      if (c >= 5) check("t4 no done", int'(done_w[0]), 0);
      if (c == 1) s_valid = 1'b0;
      if (c == 4) abort = 1'b1;
      if (c == 5) abort = 1'b0;
    end

    // 5: reset for one cycle mid-byte.
    do_reset();
    offer(8'hC3);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        check("t5 mux_in", int'(mux_in_w[0]), 0);
        check("t5 sel", int'(sel_w[0]), 0);
        check("t5 flags", int'({valid_w[0], first_w[0], last_w[0], busy_w[0], done_w[0]}), 0);
      end
      if (c == 5) check("t5 no done", int'(done_w[0]), 0);
      if (c == 1) s_valid = 1'b0;
      if (c == 3) rst_n = 1'b0;
      if (c == 4) rst_n = 1'b1;
    end

    // 6: s_valid pulsed during SHIFT is ignored.
    do_reset();
    offer(8'h5A);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("t6 mux_in", int'(mux_in_w[0]), 8'h5A);
      if (c == 1) s_valid = 1'b0;
      if (c == 3) begin s_valid = 1'b1; s_data = 8'h11; end
      if (c == 4) s_valid = 1'b0;
    end

    // Randomized traffic checked by the scoreboard.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst_n   = ($urandom_range(0, 99) != 0);
      abort   = ($urandom_range(0, 19) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    rst_n = 1'b1; s_valid = 1'b0; abort = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
